row_clear: RTL and testbench

ROW_CLEAR -- requirements
Module: Row_Clear

---
 rtl/row_clear_pkg.sv | 17 +
 rtl/row_clear.sv | 100 ++++++++++
 tb/tb_row_clear.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/row_clear_pkg.sv
// Shared game constants for the full-row scanner and the row-clear block:
// board geometry, row-index width and the row-clear FSM encoding.
package row_clear_pkg;

  localparam int DEF_BLOCKS_WIDE = 14;
  localparam int DEF_BLOCKS_HIGH = 18;
  localparam int DEF_BOARD_BITS  = DEF_BLOCKS_WIDE * DEF_BLOCKS_HIGH;
  localparam int ROW_BITS        = 5;
  localparam int LINES_BITS      = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/row_clear.sv
// Collapses one full row out of the board: every row above it moves down by
// one (one row per cycle) and row 0 becomes empty, then the result is strobed out.
module row_clear
  import row_clear_pkg::*;
#(
  parameter int BLOCKS_WIDE = DEF_BLOCKS_WIDE,
  parameter int BLOCKS_HIGH = DEF_BLOCKS_HIGH
) (
  input  logic                                 Clk,
  input  logic                                 Reset,
  input  logic                                 Pause,
  input  logic [BLOCKS_WIDE*BLOCKS_HIGH-1:0]   Game,
  input  logic [ROW_BITS-1:0]                  Row,
  input  logic                                 Enabled,
  output logic [BLOCKS_WIDE*BLOCKS_HIGH-1:0]   Game_Out,
  output logic                                 Load,
  output logic                                 Busy,
  output logic [LINES_BITS-1:0]                Lines,
  output logic [1:0]                           state_dbg
);

  localparam int BOARD_BITS = BLOCKS_WIDE * BLOCKS_HIGH;
  localparam int LO_W       = $clog2(BOARD_BITS);

  // Handshake: a clear request (Enabled with an in-range Row) is taken only in
  // IDLE with Load low and Pause low; the result is valid while Load is high,
  // for exactly one cycle, and Game_Out then holds until the next Load.

  state_t                  state, state_next;
  logic [ROW_BITS-1:0]     ptr;
  logic [BOARD_BITS-1:0]   buffer;
  logic [LO_W-1:0]         row_lo;
  logic [LO_W-1:0]         prev_lo;
  logic                    capture;

  assign Busy      = (state != ST_IDLE);
  assign state_dbg = state;

  always_comb begin
    capture = 1'b0;
    if (state == ST_IDLE && !Load && Enabled && (32'(Row) < BLOCKS_HIGH))
      capture = 1'b1;
  end

  always_comb begin
    row_lo  = LO_W'(ptr) * LO_W'(BLOCKS_WIDE);
    prev_lo = row_lo - LO_W'(BLOCKS_WIDE);
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (capture) state_next = ST_SHIFT;
      ST_SHIFT: if (ptr == '0) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      buffer   <= '0;
      Game_Out <= '0;
      Load     <= 1'b0;
      Lines    <= '0;
    end else begin
      // Load is a strobe, so it drops even on a paused cycle.
      Load <= 1'b0;
      if (!Pause) begin
        state <= state_next;
        case (state)
          ST_IDLE: begin
            if (capture) begin
              buffer <= Game;
              ptr    <= Row;
            end
          end
          ST_SHIFT: begin
            if (ptr != '0) begin
              buffer[row_lo +: BLOCKS_WIDE] <= buffer[prev_lo +: BLOCKS_WIDE];
              ptr <= ptr - 1'b1;
            end else begin
              buffer[0 +: BLOCKS_WIDE] <= '0;
            end
          end
          ST_DONE: begin
            Game_Out <= buffer;
            Load     <= 1'b1;
            if (Lines != '1)
              Lines <= Lines + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_row_clear.sv
// Bench for row_clear: random and directed clears, scoreboard of expected
// boards/line counts popped by a monitor on every Load strobe.
module tb_row_clear;
  import row_clear_pkg::*;

  localparam int W = 14;
  localparam int H = 18;
  localparam int B = W * H;
  localparam int EW = B + 8;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         Pause;
  logic [B-1:0] Game;
  logic [4:0]   Row;
  logic         Enabled;
  logic [B-1:0] Game_Out;
  logic         Load;
  logic         Busy;
  logic [7:0]   Lines;
  logic [1:0]   state_dbg;

  int errors = 0;
  int checks = 0;
  int model_lines = 0;
  logic [B-1:0]  last_out = '0;
  logic [EW-1:0] exp_q[$];

  row_clear dut (
    .Clk(Clk), .Reset(Reset), .Pause(Pause), .Game(Game), .Row(Row),
    .Enabled(Enabled), .Game_Out(Game_Out), .Load(Load), .Busy(Busy),
    .Lines(Lines), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [B-1:0] rand_board();
    logic [B-1:0] b;
    for (int i = 0; i < B; i++) b[i] = 1'($urandom_range(0, 1));
    return b;
  endfunction

  // Reference: rows above the cleared row drop by one, row 0 empties,
  // rows below the cleared row are untouched.
  function automatic logic [B-1:0] model_clear(input logic [B-1:0] g, input int row);
    logic [W-1:0] rin[H];
    logic [W-1:0] rout[H];
    logic [B-1:0] res;
    for (int r = 0; r < H; r++) rin[r] = g[r*W +: W];
    for (int r = 0; r < H; r++) begin
      if (r > row)       rout[r] = rin[r];
      else if (r == 0)   rout[r] = '0;
      else               rout[r] = rin[r-1];
    end
    for (int r = 0; r < H; r++) res[r*W +: W] = rout[r];
    return res;
  endfunction

  // monitor / scoreboard
  always @(negedge Clk) begin
    if (!Reset && Load) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_load", EW'(Load), EW'(0));
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        chk("game_out", EW'(Game_Out), EW'(e[B-1:0]));
        chk("lines", EW'(Lines), EW'(e[EW-1:B]));
      end
    end
  end

  // pmode: 0 no pause, 1 random pauses, 2 pause for three cycles mid-shift
  task automatic do_clear(input logic [B-1:0] board, input int row, input int pmode);
    int cyc;
    bit seen;
    @(negedge Clk);
    chk("hold_out", EW'(Game_Out), EW'(last_out));
    Game = board; Row = 5'(row); Enabled = 1'b1; Pause = 1'b0;
    if (row >= H) begin
      @(negedge Clk);
      chk("ignore_busy", EW'(Busy), EW'(0));
      Enabled = 1'b0;
      return;
    end
    model_lines = (model_lines < 255) ? model_lines + 1 : 255;
    last_out = model_clear(board, row);
    exp_q.push_back({8'(model_lines), last_out});
    @(negedge Clk);
    chk("busy_after_capture", EW'(Busy), EW'(1));
    cyc = 0;
    seen = 0;
    for (int n = 0; n < 200; n++) begin
      Game = rand_board();
      Row = 5'($urandom_range(0, 31));
      Enabled = 1'($urandom_range(0, 1));
      if (pmode == 1)      Pause = ($urandom_range(0, 3) == 0);
      else if (pmode == 2) Pause = (n >= 2 && n < 5);
      else                 Pause = 1'b0;
      @(posedge Clk);
      if (!Pause) cyc++;
      @(negedge Clk);
      if (Load) begin
        seen = 1;
        break;
      end
    end
    Enabled = 1'b0;
    Pause = 1'b0;
    if (!seen) chk("load_timeout", EW'(0), EW'(1));
    else       chk("latency", EW'(cyc), EW'(row + 2));
  endtask

  task automatic reset_mid_clear();
    @(negedge Clk);
    Game = rand_board(); Row = 5'd10; Enabled = 1'b1; Pause = 1'b0;
    @(negedge Clk);
    Enabled = 1'b0;
    repeat (3) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk("rst_busy", EW'(Busy), EW'(0));
    chk("rst_out", EW'(Game_Out), EW'(0));
    chk("rst_lines", EW'(Lines), EW'(0));
    chk("rst_load", EW'(Load), EW'(0));
    model_lines = 0;
    last_out = '0;
    @(negedge Clk);
    Reset = 1'b0;
    repeat (30) @(negedge Clk);
    chk("post_rst_idle", EW'(Busy), EW'(0));
  endtask

  initial begin
    logic [B-1:0] b;
    Reset = 1'b1; Pause = 1'b0; Game = '0; Row = '0; Enabled = 1'b0;
    repeat (3) @(negedge Clk);
    chk("reset_busy", EW'(Busy), EW'(0));
    chk("reset_load", EW'(Load), EW'(0));
    chk("reset_lines", EW'(Lines), EW'(0));
    chk("reset_out", EW'(Game_Out), EW'(0));
    chk("reset_state", EW'(state_dbg), EW'(ST_IDLE));
    Reset = 1'b0;

    // bottom row full, rows above hold a single low bit
    b = '0;
    for (int r = 0; r < 17; r++) b[r*W +: W] = 14'h0001;
    b[17*W +: W] = 14'h3FFF;
    do_clear(b, 17, 0);

    b = rand_board();
    b[0 +: W] = 14'h3FFF;
    do_clear(b, 0, 0);

    do_clear(rand_board(), 5, 2);

    for (int i = 0; i < 20; i++)
      do_clear(rand_board(), $urandom_range(0, 17), 1);

    reset_mid_clear();

    do_clear(rand_board(), 20, 0);

    for (int i = 0; i < 256; i++)
      do_clear(rand_board(), $urandom_range(0, 3), (i % 8 == 0) ? 1 : 0);
    @(negedge Clk);
    chk("lines_saturated", EW'(Lines), EW'(255));

    do_clear(rand_board(), 17, 1);
    repeat (3) @(negedge Clk);
    chk("queue_empty", EW'(exp_q.size()), EW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
